// File: rtl/rib_ram.sv
// -----------------------------------------------------------------------------
// rib_ram -- single-port word-organised RAM behind a simple request/ack bus.
//
// An access is accepted in IDLE when req_i is high. The request fields are
// captured on that edge, optional wait states are counted, and the memory
// write / read-data update happens on the edge that enters RESP. ack_o then
// pulses for one cycle. Addresses whose word index is at or beyond DEPTH are
// answered with err_o=1, leave memory untouched and return zero read data.
//
// Ports
//   clk     system clock, rising-edge active
//   rst     asynchronous active-low reset
//   req_i   access request, held by the master until ack_o
//   we_i    1 = write, 0 = read
//   addr_i  byte address (low byte-offset bits ignored)
//   sel_i   byte-lane write strobes
//   data_i  write data
//   data_o  registered read data, held until the next read completes
//   ack_o   one-cycle access-complete pulse
//   err_o   out-of-range flag, meaningful while ack_o=1
//   busy_o  high whenever an access is in flight
// -----------------------------------------------------------------------------
module rib_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_W/8-1:0]   sel_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter preload: the WAIT state is left when the counter reads zero,
    // so loading N-1 gives exactly N wait cycles.
    localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_nx_s;

    // Captured request fields
    logic                we_r;
    logic [MEM_AW-1:0]   idx_r;
    logic [BYTES-1:0]    sel_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                inr_r;

    // Address decode of the live request
    logic [31:0]         word_idx_s;
    logic                in_range_s;

    // Fields of the access being committed (live inputs when committing
    // straight out of IDLE, captured copies otherwise)
    logic                acc_we_s;
    logic [MEM_AW-1:0]   acc_idx_s;
    logic [BYTES-1:0]    acc_sel_s;
    logic [DATA_W-1:0]   acc_wdata_s;
    logic                acc_inr_s;
    logic                commit_s;

    logic [DATA_W-1:0]   data_r;
    logic                ack_r;
    logic                err_r;
    logic                busy_r;

    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Merge new write data into an existing word, lane by lane.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BYTES-1:0]  lane_en
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BYTES; b++) begin
            if (lane_en[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Word index and range check over the full 32-bit address.
    always_comb begin
        word_idx_s = addr_i >> OFF_W;
        in_range_s = (word_idx_s < DEPTH_W);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = WAIT_LOAD;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_nx_s = ST_RESP;
                end else begin
                    cnt_nx_s = cnt_r - 3'd1;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 3'd0;
            end
        endcase
    end

    // Select the fields of the access that commits on this edge.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s    = we_i;
            acc_idx_s   = word_idx_s[MEM_AW-1:0];
            acc_sel_s   = sel_i;
            acc_wdata_s = data_i;
            acc_inr_s   = in_range_s;
        end else begin
            acc_we_s    = we_r;
            acc_idx_s   = idx_r;
            acc_sel_s   = sel_r;
            acc_wdata_s = wdata_r;
            acc_inr_s   = inr_r;
        end
        commit_s = (state_nx_s == ST_RESP);
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Capture request fields when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            idx_r   <= {MEM_AW{1'b0}};
            sel_r   <= {BYTES{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            inr_r   <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_i) begin
            we_r    <= we_i;
            idx_r   <= word_idx_s[MEM_AW-1:0];
            sel_r   <= sel_i;
            wdata_r <= data_i;
            inr_r   <= in_range_s;
        end
    end

    // Memory array write port; contents are deliberately not reset. The rst
    // term keeps a request seen during reset from touching memory.
    always_ff @(posedge clk) begin
        if (commit_s && rst && acc_we_s && acc_inr_s) begin
            mem_r[acc_idx_s] <= merge_lanes(mem_r[acc_idx_s], acc_wdata_s, acc_sel_s);
        end
    end

    // Registered response outputs; read data only moves when a read commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= {DATA_W{1'b0}};
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            ack_r  <= commit_s;
            err_r  <= commit_s & ~acc_inr_s;
            busy_r <= (state_nx_s != ST_IDLE);
            if (commit_s && !acc_we_s) begin
                data_r <= acc_inr_s ? mem_r[acc_idx_s] : {DATA_W{1'b0}};
            end
        end
    end

    assign data_o = data_r;
    assign ack_o  = ack_r;
    assign err_o  = err_r;
    assign busy_o = busy_r;

endmodule

// File: doc/rib_ram.md
RIB_RAM -- requirements
Module: rib_ram

Interface
REQ-001 Parameter DATA_W, default 32, meaning data word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4096, meaning number of DATA_W words; legal range 2..65536, not required to be a power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, meaning extra wait states per access; legal range 0..7.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 req_i  input  1  access request; held high by the master until ack_o is seen.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 addr_i  input  32  byte address.
REQ-009 sel_i  input  DATA_W/8  byte-lane write strobes.
REQ-010 data_i  input  DATA_W  write data.
REQ-011 data_o  output  DATA_W  read data, registered.
REQ-012 ack_o  output  1  one-cycle access-complete pulse.
REQ-013 err_o  output  1  out-of-range flag, valid only while ack_o=1.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 Word index = addr_i >> log2(DATA_W/8); low byte-offset bits ignored, no misalignment error.
REQ-016 Address in range iff word index < DEPTH, evaluated over all 32 address bits.
REQ-017 FSM states IDLE, WAIT, RESP; req_i sampled only in IDLE.
REQ-018 IDLE with req_i=1: capture we_i, word index, sel_i, data_i, range flag; go to RESP if WAIT_CYCLES=0, else WAIT with 3-bit counter loaded to WAIT_CYCLES-1.
REQ-019 WAIT: counter decrements each cycle; at counter=0 go to RESP.
REQ-020 Memory write and read-data register update occur on the edge entering RESP, using captured values only.
REQ-021 RESP: ack_o=1 for exactly one cycle, then unconditional return to IDLE.
REQ-022 Latency: ack_o high exactly WAIT_CYCLES+1 cycles after the accepting edge; sustained throughput one access per WAIT_CYCLES+2 cycles.
REQ-023 Write: only byte lanes with sel_i bit set updated; sel_i all-zero is a no-op but still acked with err_o=0.
REQ-024 Read: full word returned on data_o, sel_i ignored; data_o holds value until next read completes, unchanged by writes.
REQ-025 Out-of-range access: no memory write; read returns data_o=0; ack_o=1 with err_o=1.
REQ-026 req_i still high in the cycle after ack_o is treated as a new request; master drops req_i on seeing ack_o.
REQ-027 Changes to addr_i, data_i, sel_i or we_i after acceptance have no effect on the in-flight access.
REQ-028 Read following a write to the same word returns the written data, no stale value.

Reset
REQ-029 rst=0 forces IDLE, wait counter=0, ack_o=0, err_o=0, busy_o=0, data_o=0 immediately, independent of clk.
REQ-030 Memory array is not reset; contents are undefined until written.
REQ-031 Reset asserted in WAIT before the commit edge aborts the access: no write performed, no ack_o issued.
REQ-032 First request accepted on the first rising edge with rst=1 and req_i=1.

Verification
REQ-033 WAIT_CYCLES=0, DATA_W=32: write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> each ack one cycle after accept, read data_o=0xDEADBEEF, err_o=0.
REQ-034 Byte strobes: word at 0x20 = 0x11223344, write 0xAABBCCDD with sel=0x5 -> read returns 0x11BB33DD; write with sel=0x0 -> word unchanged, ack_o=1.
REQ-035 WAIT_CYCLES=3: read request -> ack_o exactly 4 cycles after accept, busy_o high for 4 cycles; input changes during WAIT do not alter the result.
REQ-036 DEPTH=1000, DATA_W=32: write to byte address 4000 -> ack_o=1, err_o=1, no write; read of address 3996 succeeds with err_o=0.
REQ-037 WAIT_CYCLES=5: assert rst=0 mid-WAIT of a write to 0x40 -> outputs zero asynchronously, no ack_o; after release, read 0x40 -> old contents preserved.
REQ-038 DATA_W=64: back-to-back write/read at 0x08 with sel=0xF0 -> only upper 32 bits updated; ack_o spacing = WAIT_CYCLES+2 cycles.
